// File: rtl/vga_timing_pkg.sv
// Raster timing constants and phase decode shared by the VGA timing slice.
// Holds the 640x480@60 defaults and an 800x600@60 alternate set.
package vga_timing_pkg;

  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;
  localparam int VGA_V_ACTIVE = 480;

  localparam int SVGA_H_FP     = 40;
  localparam int SVGA_H_SYNC   = 128;
  localparam int SVGA_H_BP     = 88;
  localparam int SVGA_H_ACTIVE = 800;
  localparam int SVGA_V_FP     = 1;
  localparam int SVGA_V_SYNC   = 4;
  localparam int SVGA_V_BP     = 23;
  localparam int SVGA_V_ACTIVE = 600;

  typedef logic [1:0] phase_t;

  localparam phase_t PH_FP   = 2'd0;
  localparam phase_t PH_SYNC = 2'd1;
  localparam phase_t PH_BP   = 2'd2;
  localparam phase_t PH_ACT  = 2'd3;

  function automatic phase_t phase_of(
    input int c,
    input int fp,
    input int sy,
    input int bl
  );
    phase_t ph;
    unique case (1'b1)
      (c < fp):                   ph = PH_FP;
      (c >= fp && c < fp + sy):   ph = PH_SYNC;
      (c >= fp + sy && c < bl):   ph = PH_BP;
      default:                    ph = PH_ACT;
    endcase
    return ph;
  endfunction

endpackage

// File: rtl/vga_timing_if.sv
// Timing outputs of the raster generator, plus the optional
// runtime size-config handshake (VGA_TIMING_RUNTIME_CFG_EN).
interface vga_timing_if #(
  parameter int CW = 10
);

  logic          h_sync;
  logic          v_sync;
  logic          h_active;
  logic          v_active;
  logic          video_on;
  logic          end_line;
  logic          end_frame;
  logic [CW-1:0] h_count;
  logic [CW-1:0] v_count;
  logic [CW-1:0] pixel_x;
  logic [CW-1:0] pixel_y;
`ifdef VGA_TIMING_RUNTIME_CFG_EN
  logic          cfg_valid;
  logic          cfg_ready;
  logic [CW-1:0] cfg_h_active;
  logic [CW-1:0] cfg_v_active;
`endif

  modport master (
`ifdef VGA_TIMING_RUNTIME_CFG_EN
    input  cfg_valid,
    input  cfg_h_active,
    input  cfg_v_active,
    output cfg_ready,
`endif
    output h_sync,
    output v_sync,
    output h_active,
    output v_active,
    output video_on,
    output end_line,
    output end_frame,
    output h_count,
    output v_count,
    output pixel_x,
    output pixel_y
  );

  modport slave (
`ifdef VGA_TIMING_RUNTIME_CFG_EN
    output cfg_valid,
    output cfg_h_active,
    output cfg_v_active,
    input  cfg_ready,
`endif
    input  h_sync,
    input  v_sync,
    input  h_active,
    input  v_active,
    input  video_on,
    input  end_line,
    input  end_frame,
    input  h_count,
    input  v_count,
    input  pixel_x,
    input  pixel_y
  );

endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: phase counter with sync/active/position decoded
// from the next count so every output matches the count it accompanies.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int FP     = VGA_H_FP,
  parameter int SYNC   = VGA_H_SYNC,
  parameter int BP     = VGA_H_BP,
  parameter int ACTIVE = VGA_H_ACTIVE,
  parameter bit POL    = 1'b0,
  parameter int CW     = 10
) (
  input  logic          clk,
  input  logic          rst_,
  input  logic          tick,
  input  logic [CW-1:0] active_len,
  output logic [CW-1:0] count,
  output logic [CW-1:0] pos,
  output logic          sync,
  output logic          active,
  output logic          active_nxt,
  output logic          last_nxt
);

  localparam int BLANK = FP + SYNC + BP;
  localparam logic [CW-1:0] BLANK_W = CW'(BLANK);
  localparam logic [CW-1:0] ONE     = CW'(1);

  if (FP == 0 || SYNC == 0 || BP == 0 || ACTIVE == 0) begin : g_bad_len
    $error("vga_axis_counter: zero-length phase");
  end
  if (BLANK + ACTIVE > 2**CW) begin : g_bad_cw
    $error("vga_axis_counter: total exceeds 2**CW");
  end

  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] pos_q, pos_d;
  logic [CW-1:0] last_cnt;
  logic          sync_q, sync_d;
  logic          active_q, active_d;
  logic          last_q, last_d;
  phase_t        ph;

  always_comb begin
    last_cnt = BLANK_W + active_len - ONE;
    count_d  = count_q;
    if (tick) count_d = last_q ? '0 : count_q + ONE;
    ph       = phase_of(int'(count_d), FP, SYNC, BLANK);
    sync_d   = ~POL;
    active_d = 1'b0;
    pos_d    = '0;
    unique case (ph)
      PH_SYNC: sync_d = POL;
      PH_ACT: begin
        active_d = 1'b1;
        pos_d    = count_d - BLANK_W;
      end
      default: ;
    endcase
    last_d = (count_d == last_cnt);
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      count_q  <= '0;
      pos_q    <= '0;
      sync_q   <= ~POL;
      active_q <= 1'b0;
      last_q   <= 1'b0;
    end else begin
      count_q  <= count_d;
      pos_q    <= pos_d;
      sync_q   <= sync_d;
      active_q <= active_d;
      last_q   <= last_d;
    end
  end

  assign count      = count_q;
  assign pos        = pos_q;
  assign sync       = sync_q;
  assign active     = active_q;
  assign active_nxt = active_d;
  assign last_nxt   = last_d;

endmodule

// File: rtl/vga_timing_gen.sv
// Two-axis raster timing generator (h/v sync, active, markers, coords).
// VGA_TIMING_RUNTIME_CFG_EN adds a shadowed runtime active-size config.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_FP       = VGA_H_FP,
  parameter int H_SYNC     = VGA_H_SYNC,
  parameter int H_BP       = VGA_H_BP,
  parameter int H_ACTIVE   = VGA_H_ACTIVE,
  parameter int V_FP       = VGA_V_FP,
  parameter int V_SYNC     = VGA_V_SYNC,
  parameter int V_BP       = VGA_V_BP,
  parameter int V_ACTIVE   = VGA_V_ACTIVE,
  parameter bit H_SYNC_POL = 1'b0,
  parameter bit V_SYNC_POL = 1'b0,
  parameter int CW         = 10
) (
  input  logic clk,
  input  logic rst_,
  input  logic enable,
  vga_timing_if.master vif
);

  logic [CW-1:0] h_len, v_len;
  logic h_act, v_act, h_act_nxt, v_act_nxt;
  logic h_last_nxt, v_last_nxt, v_tick;
  logic video_on_q, video_on_d;
  logic end_line_q, end_line_d;
  logic end_frame_q, end_frame_d;

  assign v_tick = enable & end_line_q;

  vga_axis_counter #(
    .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .ACTIVE(H_ACTIVE),
    .POL(H_SYNC_POL), .CW(CW)
  ) u_h (
    .clk        (clk),
    .rst_       (rst_),
    .tick       (enable),
    .active_len (h_len),
    .count      (vif.h_count),
    .pos        (vif.pixel_x),
    .sync       (vif.h_sync),
    .active     (h_act),
    .active_nxt (h_act_nxt),
    .last_nxt   (h_last_nxt)
  );

  vga_axis_counter #(
    .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .ACTIVE(V_ACTIVE),
    .POL(V_SYNC_POL), .CW(CW)
  ) u_v (
    .clk        (clk),
    .rst_       (rst_),
    .tick       (v_tick),
    .active_len (v_len),
    .count      (vif.v_count),
    .pos        (vif.pixel_y),
    .sync       (vif.v_sync),
    .active     (v_act),
    .active_nxt (v_act_nxt),
    .last_nxt   (v_last_nxt)
  );

  always_comb begin
    video_on_d  = h_act_nxt & v_act_nxt;
    end_line_d  = h_last_nxt;
    end_frame_d = h_last_nxt & v_last_nxt;
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      video_on_q  <= 1'b0;
      end_line_q  <= 1'b0;
      end_frame_q <= 1'b0;
    end else begin
      video_on_q  <= video_on_d;
      end_line_q  <= end_line_d;
      end_frame_q <= end_frame_d;
    end
  end

  assign vif.h_active  = h_act;
  assign vif.v_active  = v_act;
  assign vif.video_on  = video_on_q;
  assign vif.end_line  = end_line_q;
  assign vif.end_frame = end_frame_q;

`ifdef VGA_TIMING_RUNTIME_CFG_EN
  logic          pend_q, pend_d;
  logic          apply;
  logic [CW-1:0] sh_h_q, sh_h_d, sh_v_q, sh_v_d;
  logic [CW-1:0] h_len_q, h_len_d, v_len_q, v_len_d;

  // Sizes only switch on the wrap out of end_frame, so both axes restart at (0,0).
  assign apply = enable & end_frame_q & pend_q;

  always_comb begin
    pend_d  = pend_q;
    sh_h_d  = sh_h_q;
    sh_v_d  = sh_v_q;
    h_len_d = h_len_q;
    v_len_d = v_len_q;
    if (vif.cfg_valid && !pend_q) begin
      pend_d = 1'b1;
      sh_h_d = (vif.cfg_h_active == '0) ? CW'(H_ACTIVE) : vif.cfg_h_active;
      sh_v_d = (vif.cfg_v_active == '0) ? CW'(V_ACTIVE) : vif.cfg_v_active;
    end
    if (apply) begin
      pend_d  = 1'b0;
      h_len_d = sh_h_q;
      v_len_d = sh_v_q;
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      pend_q  <= 1'b0;
      sh_h_q  <= CW'(H_ACTIVE);
      sh_v_q  <= CW'(V_ACTIVE);
      h_len_q <= CW'(H_ACTIVE);
      v_len_q <= CW'(V_ACTIVE);
    end else begin
      pend_q  <= pend_d;
      sh_h_q  <= sh_h_d;
      sh_v_q  <= sh_v_d;
      h_len_q <= h_len_d;
      v_len_q <= v_len_d;
    end
  end

  assign h_len         = h_len_q;
  assign v_len         = v_len_q;
  assign vif.cfg_ready = ~pend_q;
`else
  assign h_len = CW'(H_ACTIVE);
  assign v_len = CW'(V_ACTIVE);
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: full 800-clock lines, a short
// 16-line frame to keep runtime small, stall, async reset, runtime cfg.
module tb_vga_timing_gen;

  localparam int CW = 10;

  logic clk    = 1'b0;
  logic rst_   = 1'b0;
  logic enable = 1'b0;
  int   n_vec  = 0;
  int   n_err  = 0;

  vga_timing_if #(.CW(CW)) vif ();

  vga_timing_gen #(
    .H_FP(16), .H_SYNC(96), .H_BP(48), .H_ACTIVE(640),
    .V_FP(2), .V_SYNC(2), .V_BP(4), .V_ACTIVE(8),
    .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b0), .CW(CW)
  ) dut (
    .clk    (clk),
    .rst_   (rst_),
    .enable (enable),
    .vif    (vif)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int hc_bad, hs_lo, hs_first, hs_last, ha_n, ha_first;
    int el_n, el_at, px_blank, px160, px799;
    int cyc, ef_at, vs_lines, vs_first, va_lines, va_first, n;
`ifdef VGA_TIMING_RUNTIME_CFG_EN
    vif.cfg_valid    = 1'b0;
    vif.cfg_h_active = '0;
    vif.cfg_v_active = '0;
`endif

    // reset
    step(5);
    chk("rst_h_count", int'(vif.h_count), 0);
    chk("rst_v_count", int'(vif.v_count), 0);
    chk("rst_h_sync", int'(vif.h_sync), 1);
    chk("rst_v_sync", int'(vif.v_sync), 1);
    chk("rst_h_active", int'(vif.h_active), 0);
    chk("rst_v_active", int'(vif.v_active), 0);
    chk("rst_video_on", int'(vif.video_on), 0);
    chk("rst_end_line", int'(vif.end_line), 0);
    chk("rst_end_frame", int'(vif.end_frame), 0);
    chk("rst_pixel_x", int'(vif.pixel_x), 0);
    chk("rst_pixel_y", int'(vif.pixel_y), 0);

    // one line
    rst_   = 1'b1;
    enable = 1'b1;
    hc_bad = 0; hs_lo = 0; hs_first = -1; hs_last = -1;
    ha_n = 0; ha_first = -1; el_n = 0; el_at = -1;
    px_blank = 0; px160 = -1; px799 = -1;
    for (int i = 0; i < 800; i++) begin
      if (int'(vif.h_count) != i) hc_bad++;
      if (!vif.h_sync) begin
        hs_lo++;
        if (hs_first < 0) hs_first = i;
        hs_last = i;
      end
      if (vif.h_active) begin
        ha_n++;
        if (ha_first < 0) ha_first = i;
      end
      if (i < 160 && vif.pixel_x != '0) px_blank++;
      if (i == 160) px160 = int'(vif.pixel_x);
      if (i == 799) px799 = int'(vif.pixel_x);
      if (vif.end_line) begin
        el_n++;
        el_at = i;
      end
      step(1);
    end
    chk("line_h_seq_errs", hc_bad, 0);
    chk("line_hs_first", hs_first, 16);
    chk("line_hs_last", hs_last, 111);
    chk("line_hs_len", hs_lo, 96);
    chk("line_ha_first", ha_first, 160);
    chk("line_ha_len", ha_n, 640);
    chk("line_px_blank_errs", px_blank, 0);
    chk("line_px_160", px160, 0);
    chk("line_px_799", px799, 639);
    chk("line_end_line_n", el_n, 1);
    chk("line_end_line_at", el_at, 799);
    chk("wrap_h_count", int'(vif.h_count), 0);
    chk("wrap_v_count", int'(vif.v_count), 1);

    // full frame
    cyc = 800; ef_at = -1;
    vs_lines = 0; vs_first = -1; va_lines = 0; va_first = -1;
    while (cyc < 14000) begin
      if (vif.h_count == '0) begin
        if (!vif.v_sync) begin
          vs_lines++;
          if (vs_first < 0) vs_first = int'(vif.v_count);
        end
        if (vif.v_active) begin
          va_lines++;
          if (va_first < 0) va_first = int'(vif.v_count);
        end
      end
      if (vif.end_frame) begin
        ef_at = cyc;
        break;
      end
      step(1);
      cyc++;
    end
    chk("frame_end_at", ef_at, 12799);
    chk("frame_end_h", int'(vif.h_count), 799);
    chk("frame_end_v", int'(vif.v_count), 15);
    chk("frame_vs_first", vs_first, 2);
    chk("frame_vs_lines", vs_lines, 2);
    chk("frame_va_first", va_first, 8);
    chk("frame_va_lines", va_lines, 8);
    step(1);
    chk("frame_wrap_h", int'(vif.h_count), 0);
    chk("frame_wrap_v", int'(vif.v_count), 0);
    chk("frame_wrap_ef", int'(vif.end_frame), 0);

    // stall at end of line
    step(799);
    chk("stall_pre_h", int'(vif.h_count), 799);
    enable = 1'b0;
    step(7);
    chk("stall_h", int'(vif.h_count), 799);
    chk("stall_v", int'(vif.v_count), 0);
    chk("stall_end_line", int'(vif.end_line), 1);
    chk("stall_h_active", int'(vif.h_active), 1);
    chk("stall_pixel_x", int'(vif.pixel_x), 639);
    chk("stall_h_sync", int'(vif.h_sync), 1);
    enable = 1'b1;
    step(1);
    chk("resume_h", int'(vif.h_count), 0);
    chk("resume_v", int'(vif.v_count), 1);
    chk("resume_end_line", int'(vif.end_line), 0);

    // async reset mid-frame at (400,10)
    n = 0;
    while (!(vif.h_count == 10'd400 && vif.v_count == 10'd10) && n < 20000) begin
      step(1);
      n++;
    end
    chk("mid_reach_cycles", n, 7600);
    chk("mid_video_on", int'(vif.video_on), 1);
    chk("mid_pixel_x", int'(vif.pixel_x), 240);
    chk("mid_pixel_y", int'(vif.pixel_y), 2);
    #2;
    rst_ = 1'b0;
    #1;
    chk("arst_h", int'(vif.h_count), 0);
    chk("arst_v", int'(vif.v_count), 0);
    chk("arst_video_on", int'(vif.video_on), 0);
    chk("arst_h_active", int'(vif.h_active), 0);
    chk("arst_pixel_y", int'(vif.pixel_y), 0);
    step(2);
    rst_ = 1'b1;
    chk("restart_h0", int'(vif.h_count), 0);
    step(1);
    chk("restart_h1", int'(vif.h_count), 1);
    chk("restart_v0", int'(vif.v_count), 0);

`ifdef VGA_TIMING_RUNTIME_CFG_EN
    // runtime resize to 320x4 requested mid-frame
    step(1699);
    chk("cfg_pos_h", int'(vif.h_count), 100);
    chk("cfg_ready_idle", int'(vif.cfg_ready), 1);
    vif.cfg_valid    = 1'b1;
    vif.cfg_h_active = 10'd320;
    vif.cfg_v_active = 10'd4;
    step(1);
    vif.cfg_valid = 1'b0;
    chk("cfg_ready_pend", int'(vif.cfg_ready), 0);
    n = 0;
    while (!vif.end_frame && n < 20000) begin
      step(1);
      n++;
    end
    chk("cfg_old_end_h", int'(vif.h_count), 799);
    chk("cfg_old_end_v", int'(vif.v_count), 15);
    chk("cfg_ready_still_pend", int'(vif.cfg_ready), 0);
    step(1);
    chk("cfg_ready_back", int'(vif.cfg_ready), 1);
    chk("cfg_new_h0", int'(vif.h_count), 0);
    chk("cfg_new_v0", int'(vif.v_count), 0);
    n = 0;
    while (!vif.end_frame && n < 20000) begin
      step(1);
      n++;
    end
    chk("cfg_new_frame_len", n, 5759);
    chk("cfg_new_end_h", int'(vif.h_count), 479);
    chk("cfg_new_end_v", int'(vif.v_count), 11);
    chk("cfg_new_px", int'(vif.pixel_x), 319);
    chk("cfg_new_py", int'(vif.pixel_y), 3);
    step(1);
    chk("cfg_new_wrap_h", int'(vif.h_count), 0);
    chk("cfg_new_wrap_v", int'(vif.v_count), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
